add_round_key_stage: RTL and testbench

Pipeline stage directly downstream of the MixColumns stage in the unrolled AES-128 encryption datapath. It XORs the 128-bit MixColumns result with the round key for that round, tags the result with its round index, and buffers it in a small first-word-fall-through queue. The queue lets a stalled consumer back-pressure the round pipeline without losing a block. It also flags illegal round tags and counts completed blocks.

---
 rtl/add_round_key_stage.sv | 135 +++++++++++++
 tb/tb_add_round_key_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/add_round_key_stage.sv
// add_round_key_stage
//   AddRoundKey stage that follows MixColumns in the unrolled AES-128
//   encryption datapath. Each accepted block is XORed with its round key,
//   tagged with its round index and held in a first-word-fall-through queue,
//   so a stalled consumer can back-pressure the round pipeline without
//   losing a block. Completed (round-10) blocks are counted as they leave.
//
// Parameters
//   DEPTH  queue entries (power of two, >= 2)
//   CNT_W  width of blocks_done
//
// Ports
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready  input handshake; in_ready depends on occupancy only
//   in_data, in_key    128-bit state and round key, byte k = bits [8k:8k+7]
//   in_round           round tag, legal range 1..10
//   out_valid/out_ready output handshake; head entry shown combinationally
//   out_data, out_round head entry payload and tag
//   out_last           head tag equals 10
//   blocks_done        count of popped out_last entries, wraps
//   err_round          sticky illegal-round flag
//
// Build option
//   ADD_ROUND_KEY_ROUND_CHECK_EN  when defined, pushes tagged 0 or 11..15
//   are dropped and set err_round; otherwise every push is queued and
//   err_round is tied low.

module add_round_key_stage #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:127]     in_data,
  input  logic [0:127]     in_key,
  input  logic [0:3]       in_round,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:127]     out_data,
  output logic [0:3]       out_round,
  output logic             out_last,
  output logic [CNT_W-1:0] blocks_done,
  output logic             err_round
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [0:127]  mem_data  [DEPTH];
  logic [0:3]    mem_round [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic push;
  logic pop;
  logic write_en;
  logic round_legal;

  assign in_ready  = (count < FULL);
  assign out_valid = (count != '0);
  assign out_data  = mem_data[rd_ptr];
  assign out_round = mem_round[rd_ptr];
  assign out_last  = out_valid && (out_round == 4'd10);

  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign round_legal = (in_round >= 4'd1) && (in_round <= 4'd10);

`ifdef ADD_ROUND_KEY_ROUND_CHECK_EN
  // An illegal tag still counts as an accepted handshake, but the block is
  // discarded rather than written.
  assign write_en = push && round_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_round <= 1'b0;
    end else if (push && !round_legal) begin
      err_round <= 1'b1;
    end
  end
`else
  assign write_en  = push;
  assign err_round = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_data[i]  <= '0;
        mem_round[i] <= '0;
      end
    end else if (write_en) begin
      mem_data[wr_ptr]  <= in_data ^ in_key;
      mem_round[wr_ptr] <= in_round;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (write_en) begin
        wr_ptr <= PW'((32'(wr_ptr) + 1) % DEPTH);
      end
      if (pop) begin
        rd_ptr <= PW'((32'(rd_ptr) + 1) % DEPTH);
      end
      if (write_en && !pop) begin
        count <= count + CW'(1);
      end else if (!write_en && pop) begin
        count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blocks_done <= '0;
    end else if (pop && out_last) begin
      blocks_done <= blocks_done + CNT_W'(1);
    end
  end

`ifndef ADD_ROUND_KEY_ROUND_CHECK_EN
  logic unused_legal;
  assign unused_legal = round_legal;
`endif

endmodule

// File: tb/tb_add_round_key_stage.sv
module tb_add_round_key_stage;

  localparam int unsigned CNT_W = 3;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [0:127]     in_data;
  logic [0:127]     in_key;
  logic [0:3]       in_round;
  logic             out_valid;
  logic             out_ready;
  logic [0:127]     out_data;
  logic [0:3]       out_round;
  logic             out_last;
  logic [CNT_W-1:0] blocks_done;
  logic             err_round;

  int checks;
  int failures;

  add_round_key_stage #(.DEPTH(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key(in_key), .in_round(in_round),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_round(out_round), .out_last(out_last),
    .blocks_done(blocks_done), .err_round(err_round)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [127:0] d, input logic [127:0] k,
                        input logic [3:0] r);
    in_valid = v;
    in_data  = d;
    in_key   = k;
    in_round = r;
  endtask

  logic [127:0] key_c;
  logic [127:0] blk_a;
  logic [127:0] blk_b;

  initial begin
    checks   = 0;
    failures = 0;
    key_c = 128'hffff0000_ffff0000_ffff0000_ffff0000;
    blk_a = 128'h11111111_22222222_33333333_44444444;
    blk_b = 128'haaaaaaaa_bbbbbbbb_cccccccc_dddddddd;
    rst_n     = 1'b0;
    out_ready = 1'b0;
    set_in(1'b0, '0, '0, 4'd0);
    #12;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_last", 128'(out_last), 128'(0));
    chk("rst_out_data", out_data, 128'(0));
    chk("rst_out_round", 128'(out_round), 128'(0));
    chk("rst_blocks_done", 128'(blocks_done), 128'(0));
    chk("rst_err_round", 128'(err_round), 128'(0));
    rst_n = 1'b1;
    tick();

    // FIPS-197 round 1
    set_in(1'b1, 128'h046681e5e0cb199a48f8d37a2806264c,
           128'ha0fafe1788542cb123a339392a6c7605, 4'd1);
    tick();
    set_in(1'b0, '0, '0, 4'd0);
    chk("fips_valid", 128'(out_valid), 128'(1));
    chk("fips_data", out_data, 128'ha49c7ff2689f352b6b5bea43026a5049);
    chk("fips_round", 128'(out_round), 128'(1));
    chk("fips_last", 128'(out_last), 128'(0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("fips_drained", 128'(out_valid), 128'(0));

    // Back-pressure: two pushes fill the queue, third refused
    set_in(1'b1, blk_a, '0, 4'd2);
    tick();
    chk("bp_ready_after1", 128'(in_ready), 128'(1));
    set_in(1'b1, blk_b, '0, 4'd3);
    tick();
    chk("bp_ready_after2", 128'(in_ready), 128'(0));
    chk("bp_head_a", out_data, blk_a);
    set_in(1'b1, 128'hdeadbeef, '0, 4'd4);
    tick();
    chk("bp_third_refused_head", out_data, blk_a);
    chk("bp_still_full", 128'(in_ready), 128'(0));
    // Full queue refuses a push even during a simultaneous pop
    out_ready = 1'b1;
    tick();
    chk("bp_pop1_head_b", out_data, blk_b);
    chk("bp_pop1_round", 128'(out_round), 128'(3));
    chk("bp_pop1_ready", 128'(in_ready), 128'(1));
    set_in(1'b0, '0, '0, 4'd0);
    tick();
    chk("bp_empty_valid", 128'(out_valid), 128'(0));
    chk("bp_empty_ready", 128'(in_ready), 128'(1));

    // Streaming: 20 back-to-back pushes with out_ready held
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, {4{32'(i * 32'h01010101)}}, key_c, 4'd5);
      tick();
      chk("stream_valid", 128'(out_valid), 128'(1));
      chk("stream_data", out_data, {4{32'(i * 32'h01010101)}} ^ key_c);
      chk("stream_count_le1", 128'(in_ready), 128'(1));
    end
    set_in(1'b0, '0, '0, 4'd0);
    tick();
    chk("stream_drained", 128'(out_valid), 128'(0));
    chk("stream_no_last", 128'(blocks_done), 128'(0));

    // Last-round counting: alternate tag 10 / tag 9
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 128'(i), '0, (i % 2 == 0) ? 4'd10 : 4'd9);
      tick();
      chk("last_flag", 128'(out_last), (i % 2 == 0) ? 128'(1) : 128'(0));
    end
    set_in(1'b0, '0, '0, 4'd0);
    tick();
    chk("last_count5", 128'(blocks_done), 128'(5));
    // Three more tag-10 blocks wrap the 3-bit counter 5 -> 0
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, '0, '0, 4'd10);
      tick();
    end
    set_in(1'b0, '0, '0, 4'd0);
    tick();
    chk("last_wrap", 128'(blocks_done), 128'(0));
    out_ready = 1'b0;

    // Illegal round tag
    set_in(1'b1, blk_a, '0, 4'd0);
    tick();
`ifdef ADD_ROUND_KEY_ROUND_CHECK_EN
    chk("illegal_err_set", 128'(err_round), 128'(1));
    chk("illegal_dropped", 128'(out_valid), 128'(0));
    chk("illegal_ready", 128'(in_ready), 128'(1));
    set_in(1'b1, blk_b, '0, 4'd3);
    tick();
    set_in(1'b0, '0, '0, 4'd0);
    chk("illegal_next_round", 128'(out_round), 128'(3));
    chk("illegal_next_data", out_data, blk_b);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("illegal_only_one", 128'(out_valid), 128'(0));
    chk("illegal_sticky", 128'(err_round), 128'(1));
`else
    set_in(1'b0, '0, '0, 4'd0);
    chk("nocheck_err_low", 128'(err_round), 128'(0));
    chk("nocheck_queued", 128'(out_valid), 128'(1));
    chk("nocheck_round0", 128'(out_round), 128'(0));
    chk("nocheck_data", out_data, blk_a);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("nocheck_drained", 128'(out_valid), 128'(0));
`endif

    // Reset with queue full, asserted between edges
    set_in(1'b1, blk_a, '0, 4'd10);
    tick();
    set_in(1'b1, blk_b, '0, 4'd10);
    tick();
    set_in(1'b0, '0, '0, 4'd0);
    chk("full_before_rst", 128'(in_ready), 128'(0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 128'(out_valid), 128'(0));
    chk("arst_in_ready", 128'(in_ready), 128'(1));
    chk("arst_blocks_done", 128'(blocks_done), 128'(0));
    chk("arst_err_round", 128'(err_round), 128'(0));
    chk("arst_out_data", out_data, 128'(0));
    chk("arst_out_last", 128'(out_last), 128'(0));
    tick();
    rst_n = 1'b1;
    set_in(1'b1, blk_b, key_c, 4'd7);
    tick();
    set_in(1'b0, '0, '0, 4'd0);
    chk("post_rst_valid", 128'(out_valid), 128'(1));
    chk("post_rst_data", out_data, blk_b ^ key_c);
    chk("post_rst_round", 128'(out_round), 128'(7));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
